rf_wb_arbiter: RTL and testbench

- Writeback arbiter for the 32x64 integer register file of the dual-issue core.
- Four writeback sources compete for the file's two write ports: ALU way0, ALU way1, LSU and MDU.
- Grants up to two writes per cycle and drives registered write-port signals into RegFile.
- ALUs have fixed priority. LSU/MDU share leftover slots round-robin. A starvation counter guarantees LSU/MDU forward progress.

---
 rtl/rf_wb_arbiter.sv | 104 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: grants up to two of four writeback sources per cycle onto the register file write ports.
// Optional RF_WB_PERF_CNT_EN adds conflict_cnt_o, a count of cycles with at least one ungranted request.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int STARVE_MAX = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              req_valid_i,
    input  logic [19:0]             req_rd_i,
    input  logic [4*DATA_WIDTH-1:0] req_data_i,
    output logic [3:0]              req_ready_o,
    output logic                    wr0_en_o,
    output logic [4:0]              wr0_addr_o,
    output logic [DATA_WIDTH-1:0]   wr0_data_o,
    output logic                    wr1_en_o,
    output logic [4:0]              wr1_addr_o,
    output logic [DATA_WIDTH-1:0]   wr1_data_o,
    output logic [1:0]              urgent_o
`ifdef RF_WB_PERF_CNT_EN
    ,
    output logic [31:0]             conflict_cnt_o
`endif
);
    logic [4:0]            rd  [4];
    logic [DATA_WIDTH-1:0] dat [4];
    logic [7:0]            cnt_l, cnt_m;
    logic                  rr, rr_next, urg_l, urg_m;
    logic [5:0]            cand;
    logic [1:0]            src [6];
    logic [3:0]            grant;
    logic [1:0]            n, s0, s1;

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign rd[i]  = req_rd_i[5*i +: 5];
        assign dat[i] = req_data_i[DATA_WIDTH*i +: DATA_WIDTH];
    end

    assign urg_l    = cnt_l == 8'(STARVE_MAX);
    assign urg_m    = cnt_m == 8'(STARVE_MAX);
    assign urgent_o = {urg_m, urg_l};

    // Candidate list in rank order; the first two asserted entries win the ports.
    assign cand = {rr ? req_valid_i[2] & ~urg_l : req_valid_i[3] & ~urg_m,
                   rr ? req_valid_i[3] & ~urg_m : req_valid_i[2] & ~urg_l,
                   req_valid_i[1], req_valid_i[0],
                   req_valid_i[3] & urg_m, req_valid_i[2] & urg_l};
    assign src  = '{2'd2, 2'd3, 2'd0, 2'd1, rr ? 2'd3 : 2'd2, rr ? 2'd2 : 2'd3};

    always_comb begin
        grant   = '0;
        n       = '0;
        s0      = '0;
        s1      = '0;
        rr_next = rr;
        for (int k = 0; k < 6; k++) begin
            if (cand[k] && n < 2'd2) begin
                grant[src[k]] = 1'b1;
                if (n == 2'd0) s0 = src[k];
                else s1 = src[k];
                if (k >= 4) rr_next = src[k] == 2'd2;
                n = n + 2'd1;
            end
        end
    end

    assign req_ready_o = reset ? 4'b0 : grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr0_en_o   <= 1'b0;
            wr0_addr_o <= '0;
            wr0_data_o <= '0;
            wr1_en_o   <= 1'b0;
            wr1_addr_o <= '0;
            wr1_data_o <= '0;
            cnt_l      <= '0;
            cnt_m      <= '0;
            rr         <= 1'b0;
        end else begin
            // Same-rd pair: the later-ranked port 1 write survives.
            wr0_en_o <= n != 2'd0 && rd[s0] != 5'd0 && !(n == 2'd2 && rd[s0] == rd[s1]);
            wr1_en_o <= n == 2'd2 && rd[s1] != 5'd0;
            if (n != 2'd0) begin
                wr0_addr_o <= rd[s0];
                wr0_data_o <= dat[s0];
            end
            if (n == 2'd2) begin
                wr1_addr_o <= rd[s1];
                wr1_data_o <= dat[s1];
            end
            rr    <= rr_next;
            cnt_l <= (!req_valid_i[2] || grant[2]) ? 8'd0 : urg_l ? cnt_l : cnt_l + 8'd1;
            cnt_m <= (!req_valid_i[3] || grant[3]) ? 8'd0 : urg_m ? cnt_m : cnt_m + 8'd1;
        end
    end

`ifdef RF_WB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) conflict_cnt_o <= '0;
        else conflict_cnt_o <= conflict_cnt_o + 32'(|(req_valid_i & ~grant));
    end
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench for rf_wb_arbiter with a queue-based reference model.
module tb_rf_wb_arbiter;
    localparam int DW = 64;
    localparam int SM = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    req_valid;
    logic [19:0]   req_rd;
    logic [4*DW-1:0] req_data;
    logic [3:0]    req_ready;
    logic          wr0_en, wr1_en;
    logic [4:0]    wr0_addr, wr1_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic [1:0]    urgent;
`ifdef RF_WB_PERF_CNT_EN
    logic [31:0]   conflict_cnt;
`endif

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DATA_WIDTH(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_rd_i(req_rd),
        .req_data_i(req_data), .req_ready_o(req_ready),
        .wr0_en_o(wr0_en), .wr0_addr_o(wr0_addr), .wr0_data_o(wr0_data),
        .wr1_en_o(wr1_en), .wr1_addr_o(wr1_addr), .wr1_data_o(wr1_data),
        .urgent_o(urgent)
`ifdef RF_WB_PERF_CNT_EN
        , .conflict_cnt_o(conflict_cnt)
`endif
    );

    typedef struct packed {logic [3:0] rdy; logic [1:0] urg; logic [31:0] conf;} rexp_t;
    typedef struct packed {
        logic e0; logic [4:0] a0; logic [DW-1:0] d0;
        logic e1; logic [4:0] a1; logic [DW-1:0] d1;
    } wexp_t;

    rexp_t rq[$];
    wexp_t wq[$];
    int tests = 0, fails = 0;
    bit mon_en = 0;
    bit pend[4];
    logic [4:0] prd[4];
    logic [DW-1:0] pdat[4];
    int cnt[4];
    bit rr;
    int unsigned conf;
    logic [4:0] ha0, ha1;
    logic [DW-1:0] hd0, hd1;
    int g[$];
    wexp_t nw;

    task automatic chk(string name, logic [139:0] act, logic [139:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            pend[s] = 0; prd[s] = '0; pdat[s] = '0; cnt[s] = 0;
        end
        rr = 0; conf = 0; ha0 = '0; ha1 = '0; hd0 = '0; hd1 = '0;
        g = {};
    endtask

    task automatic req(int s, logic [4:0] r, logic [DW-1:0] d);
        if (!pend[s]) begin
            pend[s] = 1; prd[s] = r; pdat[s] = d;
        end
    endtask

    task automatic drive();
        for (int s = 0; s < 4; s++) begin
            req_valid[s] = pend[s];
            req_rd[5*s +: 5] = prd[s];
            req_data[DW*s +: DW] = pdat[s];
        end
    endtask

    // Rank list: urgent LSU, urgent MDU, ALU0, ALU1, then non-urgent LSU/MDU from rr.
    task automatic eval_push();
        int ord[$];
        logic [3:0] gm;
        rexp_t r;
        ord = {};
        if (pend[2] && cnt[2] == SM) ord.push_back(2);
        if (pend[3] && cnt[3] == SM) ord.push_back(3);
        if (pend[0]) ord.push_back(0);
        if (pend[1]) ord.push_back(1);
        for (int j = 0; j < 2; j++) begin
            int s;
            s = ((j == 0) == (rr == 0)) ? 2 : 3;
            if (pend[s] && cnt[s] != SM) ord.push_back(s);
        end
        g = {};
        for (int j = 0; j < ord.size() && j < 2; j++) g.push_back(ord[j]);
        gm = '0;
        foreach (g[j]) gm[g[j]] = 1'b1;
        r.rdy = gm;
        r.urg = {cnt[3] == SM, cnt[2] == SM};
        r.conf = conf;
        rq.push_back(r);
        nw = '{e0: 1'b0, a0: ha0, d0: hd0, e1: 1'b0, a1: ha1, d1: hd1};
        if (g.size() > 0) begin
            nw.a0 = prd[g[0]]; nw.d0 = pdat[g[0]];
            nw.e0 = prd[g[0]] != 0;
        end
        if (g.size() == 2) begin
            nw.a1 = prd[g[1]]; nw.d1 = pdat[g[1]];
            nw.e1 = prd[g[1]] != 0;
            if (prd[g[0]] == prd[g[1]]) nw.e0 = 1'b0;
        end
        wq.push_back(nw);
    endtask

    task automatic commit();
        bit gr[4];
        bit stall;
        gr = '{default: 0};
        foreach (g[j]) gr[g[j]] = 1;
        foreach (g[j]) if (g[j] >= 2 && cnt[g[j]] != SM) rr = (g[j] == 2);
        stall = 0;
        for (int s = 0; s < 4; s++) if (pend[s] && !gr[s]) stall = 1;
        if (stall) conf++;
        for (int s = 2; s < 4; s++)
            cnt[s] = (!pend[s] || gr[s]) ? 0 : (cnt[s] < SM ? cnt[s] + 1 : SM);
        ha0 = nw.a0; hd0 = nw.d0; ha1 = nw.a1; hd1 = nw.d1;
        for (int s = 0; s < 4; s++) if (gr[s]) pend[s] = 0;
    endtask

    task automatic cyc();
        drive();
        eval_push();
        @(posedge clk);
        #1;
        commit();
    endtask

    always @(negedge clk) begin
        rexp_t r;
        wexp_t w;
        if (mon_en) begin
            if (rq.size() > 0) begin
                r = rq.pop_front();
                chk("ready", 140'(req_ready), 140'(r.rdy));
                chk("urgent", 140'(urgent), 140'(r.urg));
`ifdef RF_WB_PERF_CNT_EN
                chk("conflict_cnt", 140'(conflict_cnt), 140'(r.conf));
`endif
            end
            if (wq.size() >= 2) begin
                w = wq.pop_front();
                chk("wr_ports", {wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data}, w);
            end
        end
    end

    initial begin
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 140'(req_ready), 140'(0));
        chk("reset_wr", {wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data}, 140'(0));
        chk("reset_urgent", 140'(urgent), 140'(0));
        reset = 1'b0;
        mon_en = 1;
        // ALU pair
        req(0, 5, 64'h11); req(1, 6, 64'h22); cyc(); cyc();
        // LSU/MDU starve behind both ALUs until urgent
        req(2, 3, 64'h33); req(3, 4, 64'h44);
        repeat (9) begin
            req(0, 1, 64'($urandom)); req(1, 2, 64'($urandom)); cyc();
        end
        cyc(); cyc();
        // LSU/MDU alone, then with ALU0 for rr alternation
        req(2, 8, 64'h88); req(3, 9, 64'h99); cyc();
        req(0, 10, 64'hA0); req(2, 11, 64'hB1); req(3, 12, 64'hC2); cyc();
        req(0, 13, 64'hD3); cyc(); cyc();
        // same-rd collision, then rd 0
        req(0, 7, 64'hA); req(1, 7, 64'hB); cyc();
        req(0, 0, 64'h5A); cyc(); cyc();
        // mid-stream reset with starvation counters at 5
        req(2, 14, 64'h1); req(3, 15, 64'h2);
        repeat (5) begin
            req(0, 16, 64'h3); req(1, 17, 64'h4); cyc();
        end
        mon_en = 0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_ready", 140'(req_ready), 140'(0));
        chk("midrst_wr", {wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data}, 140'(0));
        chk("midrst_urgent", 140'(urgent), 140'(0));
`ifdef RF_WB_PERF_CNT_EN
        chk("midrst_conflict", 140'(conflict_cnt), 140'(0));
`endif
        rq.delete();
        wq.delete();
        model_reset();
        drive();
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1;
        req(2, 18, 64'h5); req(3, 19, 64'h6);
        repeat (10) begin
            req(0, 20, 64'h7); req(1, 21, 64'h8); cyc();
        end
        // randomized traffic, small rd range mixed in to provoke collisions and rd 0
        repeat (3000) begin
            for (int s = 0; s < 4; s++)
                if (!pend[s] && $urandom_range(0, 1) == 1)
                    req(s, ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom),
                        {$urandom, $urandom});
            cyc();
        end
        repeat (3) cyc();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
